fpmult_arbiter: RTL
===================

FPMULT_ARBITER -- requirements
Module: fpmult_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 63, giving the maximum number of RUN cycles to wait for mult_done.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, NREQ bits: per-requester request level.
REQ-006 SHALL have port req_dataa, input, 32*NREQ bits: operand A of requester i, in bits [32i+31:32i].
REQ-007 SHALL have port req_datab, input, 32*NREQ bits: operand B of requester i, packed the same way.
REQ-008 SHALL have port grant, output, NREQ bits: one-hot, one-cycle acceptance pulse.
REQ-009 SHALL have port resp_valid, output, NREQ bits: one-hot, one-cycle result pulse to the owner.
REQ-010 SHALL have port resp_result, output, 32 bits: last product, shared by all requesters.
REQ-011 SHALL have port resp_err, output, 1 bit: the last response was a timeout.
REQ-012 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 SHALL have port mult_reset, output, 1 bit: drives the multiplier's reset; high parks it, low runs it.
REQ-014 SHALL have ports mult_dataa and mult_datab, outputs, 32 bits each: registered operands to the multiplier.
REQ-015 SHALL have port mult_result, input, 32 bits: the multiplier's product.
REQ-016 SHALL have port mult_done, input, 1 bit: the multiplier's completion level.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, RESP.
REQ-018 IDLE with req==0 SHALL stay in IDLE, holding mult_reset=1.
REQ-019 IDLE with req!=0 SHALL, at the clock edge:
- select a winner by round-robin, starting at (last+1) mod NREQ;
- latch the winner's operands into mult_dataa and mult_datab;
- record the winner as owner and set grant[owner]=1 for exactly one cycle;
- clear the timeout counter, set mult_reset=0 and go to RUN.
REQ-020 RUN SHALL hold mult_reset=0 and stable operands, and increment the timeout counter every cycle.
REQ-021 RUN with mult_done=1 sampled SHALL, at the edge:
- capture mult_result into resp_result and set resp_err=0;
- pulse resp_valid[owner] for one cycle;
- set last=owner, set mult_reset=1 and go to RESP.
REQ-022 RUN with counter==TIMEOUT and mult_done=0 SHALL do the same as REQ-021, except resp_result=0 and resp_err=1.
REQ-023 RESP SHALL last exactly one cycle with mult_reset=1, then go to IDLE; this guarantees at least two parked cycles, so a stale mult_done is cleared before the next RUN.
REQ-024 If mult_done=1 and the timeout are reached on the same cycle, SHALL treat it as done (resp_err=0).
REQ-025 SHALL treat a req deasserted before grant as withdrawn; req still high in IDLE after the owner's resp_valid SHALL count as a new request.
REQ-026 Requesters SHALL hold operands stable while req=1; operands are sampled only on the grant edge.
REQ-027 resp_result and resp_err SHALL hold their value until the next response.
REQ-028 Latency SHALL be: grant 1 cycle after req is sampled in IDLE; resp_valid 1 cycle after mult_done is sampled; arbiter overhead between back-to-back jobs 3 cycles (RESP, IDLE, grant edge).
REQ-029 Round-robin SHALL be starvation-free: with all req high, service order is 0,1,...,NREQ-1,0.

Reset
REQ-030 SHALL, on reset assertion, asynchronously set:
- state IDLE, last=NREQ-1, counter 0;
- grant=0, resp_valid=0, resp_result=0, resp_err=0, busy=0;
- mult_reset=1, mult_dataa=0, mult_datab=0.
REQ-031 Reset during RUN SHALL abort the job with no resp_valid; the first post-reset grant goes to the lowest asserted req.

Structure
REQ-032 SHALL place state encodings (IDLE=0, RUN=1, RESP=2) and the TIMEOUT default in shared package fpsynth_pkg.
REQ-033 SHALL use a single sub-module, rr_pick (NREQ-wide round-robin priority picker: req, last -> one-hot winner, valid).
REQ-034 The multiplier SHALL be instantiated outside this block; the arbiter only drives its ports.

Verification
REQ-035 Single job: req[1], A=0x40000000, B=0x40400000 -> grant[1] pulse, then resp_valid[1], resp_result=0x40C00000, resp_err=0.
REQ-036 Zero operand: req[0], A=0x00000000, B=0x3F800000 -> resp_result=0x00000000, resp_valid[0] within 4 cycles of grant.
REQ-037 Fairness: req=4'b1111 held high, each requester with distinct operands -> grants in order 0,1,2,3,0, and each product matches its own operands.
REQ-038 Timeout: mult_done stubbed to 0, req[2] -> resp_valid[2] exactly TIMEOUT+1 cycles after grant, resp_err=1, resp_result=0.
REQ-039 Reset mid-RUN: assert reset 3 cycles after grant[3] -> no resp_valid, all outputs at reset values, mult_reset=1; after release with req=4'b1010, grant[1] first.

Source files
------------

// File: rtl/fpsynth_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, timeout default and
// counter sizing helper.
package fpsynth_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned TimeoutDefault = 63;

    // Width of a counter that must reach the value t inclusive.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: the search starts one past the last served index and
// returns the first asserted request as a one-hot winner plus its index.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_i,
    output logic [NREQ-1:0]         winner_o,
    output logic [$clog2(NREQ)-1:0] idx_o,
    output logic                    valid_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    always_comb begin
        int unsigned cand;
        logic        found;
        cand     = 0;
        found    = 1'b0;
        winner_o = '0;
        idx_o    = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = (32'(last_i) + off) % NREQ;
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                winner_o[cand] = 1'b1;
                idx_o          = IdxW'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/fpmult_arbiter.sv
// Round-robin arbiter sharing one external floating-point multiplier among NREQ
// requesters, with a per-job timeout and a parked (reset) multiplier between jobs.
module fpmult_arbiter
    import fpsynth_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   req_dataa_i,
    input  logic [32*NREQ-1:0]   req_datab_i,
    output logic [NREQ-1:0]      grant_o,
    output logic [NREQ-1:0]      resp_valid_o,
    output logic [31:0]          resp_result_o,
    output logic                 resp_err_o,
    output logic                 busy_o,
    output logic                 mult_reset_o,
    output logic [31:0]          mult_dataa_o,
    output logic [31:0]          mult_datab_o,
    input  logic [31:0]          mult_result_i,
    input  logic                 mult_done_i
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = cnt_width(TIMEOUT);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [NREQ-1:0]     rv_q, rv_d;
    logic [31:0]         res_q, res_d;
    logic                err_q, err_d;
    logic [31:0]         da_q, da_d;
    logic [31:0]         db_q, db_d;

    logic [NREQ-1:0]     pick_onehot;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_valid;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i    (req_i),
        .last_i   (last_q),
        .winner_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    always_comb begin
        logic finish;
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        rv_d    = '0;
        res_d   = res_q;
        err_d   = err_q;
        da_d    = da_q;
        db_d    = db_q;
        finish  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_onehot[i]) begin
                            da_d = req_dataa_i[32*i +: 32];
                            db_d = req_datab_i[32*i +: 32];
                        end
                    end
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // A completion on the timeout cycle still counts as a good result.
                if (mult_done_i) begin
                    res_d  = mult_result_i;
                    err_d  = 1'b0;
                    finish = 1'b1;
                end else if (cnt_q == CntW'(TIMEOUT)) begin
                    res_d  = '0;
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            rv_d    = NREQ'(1) << owner_q;
            last_d  = owner_q;
            state_d = StResp;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            last_q  <= IdxW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            rv_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            err_q   <= err_d;
            da_q    <= da_d;
            db_q    <= db_d;
        end
    end

    // The multiplier only runs in RUN; IDLE and RESP both keep it parked.
    assign mult_reset_o  = (state_q != StRun);
    assign busy_o        = (state_q != StIdle);
    assign grant_o       = grant_q;
    assign resp_valid_o  = rv_q;
    assign resp_result_o = res_q;
    assign resp_err_o    = err_q;
    assign mult_dataa_o  = da_q;
    assign mult_datab_o  = db_q;

endmodule
